// File: rtl/hex_keypad_scanner_pkg.sv
// -----------------------------------------------------------------------------
// hex_keypad_scanner_pkg
// Shared definitions for the 4x4 hex keypad scanner:
//   - FSM state encoding (SCAN / DEBOUNCE / HELD)
//   - 16-entry key map indexed by {row, col}
//   - helper functions for key lookup and single-column detection
// -----------------------------------------------------------------------------
package hex_keypad_scanner_pkg;

  localparam logic [1:0] ST_SCAN     = 2'd0;
  localparam logic [1:0] ST_DEBOUNCE = 2'd1;
  localparam logic [1:0] ST_HELD     = 2'd2;

  // Entry {row, col}; element 0 is row 0 / column 0 (key '1').
  // Rows: r0 = 1 2 3 A, r1 = 4 5 6 B, r2 = 7 8 9 C, r3 = 0 F E D.
  localparam logic [15:0][3:0] KEY_MAP = {
    4'hD, 4'hE, 4'hF, 4'h0,
    4'hC, 4'h9, 4'h8, 4'h7,
    4'hB, 4'h6, 4'h5, 4'h4,
    4'hA, 4'h3, 4'h2, 4'h1
  };

  // Hex value of the key at (row, col).
  function automatic logic [3:0] key_lookup(input logic [1:0] row, input logic [1:0] col);
    return KEY_MAP[{row, col}];
  endfunction

  // Returns {valid, col_index}; valid only when exactly one column is low.
  function automatic logic [2:0] single_low_col(input logic [3:0] cols);
    logic [2:0] res;
    case (cols)
      4'b1110: res = 3'b1_00;
      4'b1101: res = 3'b1_01;
      4'b1011: res = 3'b1_10;
      4'b0111: res = 3'b1_11;
      default: res = 3'b0_00;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/hex_keypad_scanner_scan_tick_gen.sv
// -----------------------------------------------------------------------------
// scan_tick_gen
// Free-running prescaler producing a one-cycle scan tick every SCAN_DIV clocks.
// Ports:
//   clk   - system clock
//   rst_n - asynchronous active-low reset
//   tick  - registered one-cycle strobe, high while the prescaler is at
//           SCAN_DIV-1
// -----------------------------------------------------------------------------
module scan_tick_gen #(
  parameter int SCAN_DIV = 100000
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  localparam int CNT_W = $clog2(SCAN_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_PRE  = CNT_W'(SCAN_DIV - 2);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [CNT_W-1:0] count_r;
  logic             tick_r;

  // Prescaler wrap at SCAN_DIV-1; tick is registered one count early so it
  // is high exactly during the cycle the prescaler sits at SCAN_DIV-1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_r <= '0;
      tick_r  <= 1'b0;
    end else begin
      if (count_r == CNT_LAST) begin
        count_r <= '0;
      end else begin
        count_r <= count_r + CNT_ONE;
      end
      tick_r <= (count_r == CNT_PRE);
    end
  end

  assign tick = tick_r;

endmodule

// File: rtl/hex_keypad_scanner.sv
// -----------------------------------------------------------------------------
// hex_keypad_scanner
// Scans a 4x4 matrix keypad one row at a time, debounces press and release,
// and shifts each accepted key into a 4-digit display register.
// Ports:
//   clk       - system clock
//   rst_n     - asynchronous active-low reset
//   col_n     - keypad columns, active-low, asynchronous to clk
//   clear     - synchronous request to zero the digits register
//   row_n     - active-low row drive, exactly one bit low
//   key_code  - hex value of the last accepted key
//   key_valid - one-cycle pulse on key acceptance
//   key_held  - high while the accepted key stays pressed
//   digits    - last four accepted keys, newest in [3:0]
// -----------------------------------------------------------------------------
module hex_keypad_scanner
  import hex_keypad_scanner_pkg::*;
#(
  parameter int SCAN_DIV       = 100000,
  parameter int DEBOUNCE_TICKS = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  col_n,
  input  logic        clear,
  output logic [3:0]  row_n,
  output logic [3:0]  key_code,
  output logic        key_valid,
  output logic        key_held,
  output logic [15:0] digits
);

  // The counter only ever holds values below DEBOUNCE_TICKS; the terminal
  // value is detected on the incremented value.
  localparam int DB_W = (DEBOUNCE_TICKS > 1) ? $clog2(DEBOUNCE_TICKS) : 1;
  localparam logic [DB_W:0] DB_TERM = (DB_W + 1)'(DEBOUNCE_TICKS);
  localparam logic [DB_W:0] DB_ONE  = (DB_W + 1)'(1);

  logic [3:0]      col_meta_r;
  logic [3:0]      col_sync_r;
  logic            tick_s;

  logic [1:0]      state_r;
  logic [1:0]      state_nxt_s;
  logic [1:0]      row_r;
  logic [1:0]      row_nxt_s;
  logic [1:0]      col_lat_r;
  logic [1:0]      col_lat_nxt_s;
  logic [DB_W-1:0] db_cnt_r;
  logic [DB_W-1:0] db_cnt_nxt_s;
  logic [DB_W:0]   cnt_inc_s;
  logic            cnt_done_s;
  logic [2:0]      single_s;
  logic            accept_s;
  logic [3:0]      key_s;

  logic [3:0]      row_n_r;
  logic [3:0]      key_code_r;
  logic            key_valid_r;
  logic            key_held_r;
  logic [15:0]     digits_r;

  scan_tick_gen #(
    .SCAN_DIV (SCAN_DIV)
  ) u_scan_tick_gen (
    .clk   (clk),
    .rst_n (rst_n),
    .tick  (tick_s)
  );

  // Two-flop synchronizer for the asynchronous column inputs (idle = all high).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_meta_r <= 4'b1111;
      col_sync_r <= 4'b1111;
    end else begin
      col_meta_r <= col_n;
      col_sync_r <= col_meta_r;
    end
  end

  assign single_s   = single_low_col(col_sync_r);
  assign cnt_inc_s  = {1'b0, db_cnt_r} + DB_ONE;
  assign cnt_done_s = (cnt_inc_s == DB_TERM);
  assign key_s      = key_lookup(row_r, col_lat_r);

  // Next-state logic: all transitions happen only on scan ticks.
  always_comb begin
    state_nxt_s   = state_r;
    row_nxt_s     = row_r;
    col_lat_nxt_s = col_lat_r;
    db_cnt_nxt_s  = db_cnt_r;
    accept_s      = 1'b0;
    if (tick_s) begin
      case (state_r)
        ST_SCAN: begin
          if (single_s[2]) begin
            col_lat_nxt_s = single_s[1:0];
            db_cnt_nxt_s  = '0;
            state_nxt_s   = ST_DEBOUNCE;
          end else begin
            row_nxt_s = row_r + 2'd1;
          end
        end
        ST_DEBOUNCE: begin
          if (single_s[2] && (single_s[1:0] == col_lat_r)) begin
            if (cnt_done_s) begin
              accept_s     = 1'b1;
              db_cnt_nxt_s = '0;
              state_nxt_s  = ST_HELD;
            end else begin
              db_cnt_nxt_s = cnt_inc_s[DB_W-1:0];
            end
          end else begin
            db_cnt_nxt_s = '0;
            row_nxt_s    = row_r + 2'd1;
            state_nxt_s  = ST_SCAN;
          end
        end
        ST_HELD: begin
          // Any low column (the same key or another one) restarts release timing.
          if (col_sync_r == 4'b1111) begin
            if (cnt_done_s) begin
              db_cnt_nxt_s = '0;
              row_nxt_s    = row_r + 2'd1;
              state_nxt_s  = ST_SCAN;
            end else begin
              db_cnt_nxt_s = cnt_inc_s[DB_W-1:0];
            end
          end else begin
            db_cnt_nxt_s = '0;
          end
        end
        default: begin
          state_nxt_s  = ST_SCAN;
          row_nxt_s    = 2'd0;
          db_cnt_nxt_s = '0;
        end
      endcase
    end else begin
      state_nxt_s = state_r;
    end
  end

  // FSM registers plus row drive and held flag, kept in step with the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= ST_SCAN;
      row_r      <= 2'd0;
      col_lat_r  <= 2'd0;
      db_cnt_r   <= '0;
      row_n_r    <= 4'b1110;
      key_held_r <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      row_r      <= row_nxt_s;
      col_lat_r  <= col_lat_nxt_s;
      db_cnt_r   <= db_cnt_nxt_s;
      row_n_r    <= ~(4'b0001 << row_nxt_s);
      key_held_r <= (state_nxt_s == ST_HELD);
    end
  end

  // Accepted-key outputs: pulse, code, and digit shift register with clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_valid_r <= 1'b0;
      key_code_r  <= 4'h0;
      digits_r    <= 16'h0000;
    end else begin
      key_valid_r <= accept_s;
      if (accept_s) begin
        key_code_r <= key_s;
      end else begin
        key_code_r <= key_code_r;
      end
      // A clear in the accept cycle keeps only the new key.
      if (accept_s && clear) begin
        digits_r <= {12'h000, key_s};
      end else if (accept_s) begin
        digits_r <= {digits_r[11:0], key_s};
      end else if (clear) begin
        digits_r <= 16'h0000;
      end else begin
        digits_r <= digits_r;
      end
    end
  end

  assign row_n     = row_n_r;
  assign key_code  = key_code_r;
  assign key_valid = key_valid_r;
  assign key_held  = key_held_r;
  assign digits    = digits_r;

endmodule
